move_collector: RTL and testbench
=================================

MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, single-cycle pulse that begins a collection pass; sampled only in IDLE.
REQ-004 SHALL have port all_done, input, 1, AND of every square unit's done; high when all square FIFOs are fully written.
REQ-005 SHALL have port sq_sel, output, 6, index of the square FIFO being drained; drives an external 64:1 mux; reset 0.
REQ-006 SHALL have port fifo_q, input, 160, muxed FIFO read word: [159:152] pad, then 8 slots of 19 bits, slot 7 at [151:133] down to slot 0 at [18:0].
REQ-007 SHALL have port fifo_empty, input, 1, muxed empty flag of the selected FIFO.
REQ-008 SHALL have port rden, output, 1, read request to the selected FIFO; reset 0.
REQ-009 SHALL have port mv_data, output, 19, one move: [18:12] flag bits [invalid, promote, pawn move, pawn 2 sq, en passant, castle, capture], [11:6] from, [5:0] to; reset 0.
REQ-010 SHALL have port mv_valid, output, 1, mv_data holds a move; reset 0.
REQ-011 SHALL have port mv_ready, input, 1, downstream accepts; a transfer occurs when mv_valid and mv_ready are both high on a clock edge.
REQ-012 SHALL have port move_count, output, 8, number of moves transferred this pass; saturates at 255; reset 0.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE; reset 0.
REQ-014 SHALL have port pass_done, output, 1, single-cycle pulse when a pass completes; reset 0.

Function
REQ-015 SHALL have the states IDLE, WAIT, SETTLE, CHECK, READ, LATCH, EMIT, NEXT and FIN.
REQ-016 In IDLE, start SHALL clear move_count, set sq_sel to 0 and go to WAIT.
REQ-017 WAIT SHALL hold until all_done is high, then go to SETTLE.
REQ-018 SETTLE SHALL last one cycle so the mux outputs settle after an sq_sel change, then go to CHECK.
REQ-019 In CHECK, fifo_empty=1 SHALL go to NEXT; fifo_empty=0 SHALL go to READ.
REQ-020 READ SHALL assert rden for exactly one cycle, then go to LATCH.
REQ-021 The FIFO SHALL be treated as normal (non-show-ahead) mode: fifo_q is valid in the cycle after rden.
REQ-022 LATCH SHALL capture fifo_q[151:0] into an internal word register.
REQ-023 LATCH SHALL build an 8-bit pending mask: a slot's bit is set when the slot's bit 18 is 0.
REQ-024 LATCH SHALL go to EMIT if the mask is non-zero, otherwise to CHECK.
REQ-025 EMIT SHALL present pending slots in order from highest (slot 7) to lowest, one at a time on mv_data with mv_valid=1.
REQ-026 In EMIT, mv_data and mv_valid SHALL stay stable until the transfer completes; mv_ready may stay low indefinitely.
REQ-027 On each transfer, EMIT SHALL clear that slot's mask bit and increment move_count, which saturates at 255.
REQ-028 A new slot SHALL be presented in the cycle after a transfer, so back-to-back transfers run at one per cycle.
REQ-029 Once the last pending slot transfers, the next state SHALL be CHECK.
REQ-030 The pad bits [159:152] and invalid slots SHALL never be emitted.
REQ-031 NEXT SHALL go to FIN when sq_sel=63; otherwise it SHALL increment sq_sel and go to SETTLE (no wrap past 63).
REQ-032 FIN SHALL pulse pass_done for one cycle and return to IDLE; move_count and sq_sel SHALL hold until the next start.
REQ-033 A start pulse received while busy=1 SHALL be ignored.
REQ-034 rden SHALL be asserted only in READ, and therefore never while fifo_empty=1 is observed.

Reset
REQ-035 While reset_n is low, the block SHALL enter IDLE and drive every output to the reset value listed above.
REQ-036 Clearing the internal word and mask SHALL be immediate and asynchronous, including when reset hits mid-pass.
REQ-037 After a reset the block SHALL not resume a pass; a partially drained FIFO is cleared by the square unit's own reset.

Structure
REQ-038 The move field widths, flag bit positions, slot count (8) and slot width (19) SHALL be defined in the shared chess package, together with the square FIFO word layout.
REQ-039 There SHALL be one sub-module, move_slot_picker: combinational, taking the 8-bit mask and returning the index of the highest set bit plus an any flag.

Verification
REQ-040 All 64 FIFOs empty, start, all_done=1 -> no rden, mv_valid never high, pass_done after 64 CHECK visits, move_count=0.
REQ-041 Square 12 FIFO holds one word with slots 7 and 2 valid (mv 0x00C1C, 0x04C1C), mv_ready=1 -> exactly these two moves emitted in that order on consecutive cycles, move_count=2.
REQ-042 Same as REQ-041 but mv_ready held low for 5 cycles -> mv_data stable and mv_valid high for all 5 cycles, no loss or duplication.
REQ-043 Square 0 FIFO holds 2 words with all 8 slots valid, and square 63 holds 1 word with all 8 slots invalid -> 16 moves emitted, 3 rden pulses in total, move_count=16.
REQ-044 Load 40 full words (320 moves) -> move_count saturates at 255, and all 320 moves are still transferred.
REQ-045 Assert reset_n low during EMIT on square 30 -> outputs return to reset values immediately; a fresh start then proceeds normally from square 0.

Source files
------------

// File: rtl/move_collector_pkg.sv
// Shared chess move definitions and the square FIFO word layout.
//   move_t : one 19-bit move, [18:12] flags, [11:6] from, [5:0] to
//   word_t : 8 packed slots of one FIFO word, slot 7 highest
//   state_t: collector FSM states
package move_collector_pkg;

    localparam int NUM_SQ    = 64;
    localparam int SQ_W      = 6;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 19;
    localparam int IDX_W     = $clog2(NUM_SLOTS);
    localparam int WORD_W    = NUM_SLOTS * SLOT_W;   // 152 payload bits
    localparam int FIFO_W    = 160;                  // payload + 8 pad bits
    localparam int CNT_W     = 8;

    // Move field positions
    localparam int TO_LSB    = 0;
    localparam int FROM_LSB  = 6;
    localparam int FLAG_LSB  = 12;
    localparam int FLAG_W    = 7;

    // Flag bit positions inside a move
    localparam int FLG_CAPTURE = 12;
    localparam int FLG_CASTLE  = 13;
    localparam int FLG_EP      = 14;
    localparam int FLG_PAWN2   = 15;
    localparam int FLG_PAWN    = 16;
    localparam int FLG_PROMOTE = 17;
    localparam int FLG_INVALID = 18;

    typedef logic [SLOT_W-1:0] move_t;
    typedef logic [NUM_SLOTS-1:0][SLOT_W-1:0] word_t;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_SETTLE, S_CHECK, S_READ,
        S_LATCH, S_EMIT, S_NEXT, S_FIN
    } state_t;

    // A slot is pending when its invalid flag is clear.
    function automatic logic [NUM_SLOTS-1:0] pending_mask(input word_t w);
        logic [NUM_SLOTS-1:0] m;
        for (int i = 0; i < NUM_SLOTS; i++) m[i] = ~w[i][FLG_INVALID];
        return m;
    endfunction

endpackage

// File: rtl/move_collector_if.sv
// Bus between the move collector and its environment.
//   control : start, all_done in; busy, pass_done, move_count out
//   fifo    : sq_sel, rden out; fifo_q, fifo_empty in (external 64:1 mux)
//   moves   : mv_data, mv_valid out; mv_ready in
// master = collector side, slave = environment side.
interface move_collector_if;
    import move_collector_pkg::*;

    logic              start;
    logic              all_done;
    logic [SQ_W-1:0]   sq_sel;
    logic [FIFO_W-1:0] fifo_q;
    logic              fifo_empty;
    logic              rden;
    move_t             mv_data;
    logic              mv_valid;
    logic              mv_ready;
    logic [CNT_W-1:0]  move_count;
    logic              busy;
    logic              pass_done;

    modport master (
        input  start, all_done, fifo_q, fifo_empty, mv_ready,
        output sq_sel, rden, mv_data, mv_valid, move_count, busy, pass_done
    );

    modport slave (
        output start, all_done, fifo_q, fifo_empty, mv_ready,
        input  sq_sel, rden, mv_data, mv_valid, move_count, busy, pass_done
    );

endinterface

// File: rtl/move_slot_picker.sv
// Combinational priority picker over the pending-slot mask.
//   mask : pending slots, bit i = slot i
//   idx  : index of the highest set bit (0 when mask is empty)
//   any  : mask is non-zero
module move_slot_picker
    import move_collector_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] mask,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    // Ascending scan so the highest set bit is the last to win.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (mask[i]) idx = IDX_W'(i);
    end

    assign any = |mask;

endmodule

// File: rtl/move_collector.sv
// Drains the 64 square FIFOs in order after all square units finish,
// streaming every valid move slot out on a valid/ready channel.
//   clk, reset_n : clock, async active-low reset
//   bus          : move_collector_if.master (control, FIFO mux, move stream)
module move_collector
    import move_collector_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    move_collector_if.master bus
);

    state_t               state, state_nxt;
    word_t                word;
    logic [NUM_SLOTS-1:0] mask, mask_left;
    logic [IDX_W-1:0]     pick;
    logic                 any;
    logic [SQ_W-1:0]      sq_sel;
    logic [CNT_W-1:0]     move_count;
    word_t                fifo_word;
    logic                 xfer;
    logic                 pad_unused;

    move_slot_picker u_pick (.mask(mask), .idx(pick), .any(any));

    assign fifo_word  = word_t'(bus.fifo_q[WORD_W-1:0]);
    assign pad_unused = ^bus.fifo_q[FIFO_W-1:WORD_W];
    assign mask_left  = mask & ~(NUM_SLOTS'(1) << pick);
    assign xfer       = bus.mv_valid && bus.mv_ready;

    // Outputs decode from state, so async reset drives them to idle
    // values immediately.
    assign bus.rden       = (state == S_READ);
    assign bus.mv_valid   = (state == S_EMIT) && any;
    assign bus.mv_data    = bus.mv_valid ? word[pick] : '0;
    assign bus.busy       = (state != S_IDLE);
    assign bus.pass_done  = (state == S_FIN);
    assign bus.sq_sel     = sq_sel;
    assign bus.move_count = move_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start)    state_nxt = S_WAIT;
            S_WAIT:   if (bus.all_done) state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_CHECK;
            S_CHECK:  state_nxt = bus.fifo_empty ? S_NEXT : S_READ;
            S_READ:   state_nxt = S_LATCH;
            // fifo_q is valid now, one cycle after rden.
            S_LATCH:  state_nxt = |pending_mask(fifo_word) ? S_EMIT : S_CHECK;
            S_EMIT: begin
                if (!any)                      state_nxt = S_CHECK;
                else if (xfer && mask_left == '0) state_nxt = S_CHECK;
            end
            S_NEXT:   state_nxt = (sq_sel == SQ_W'(NUM_SQ - 1)) ? S_FIN : S_SETTLE;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sq_sel     <= '0;
            move_count <= '0;
            word       <= '0;
            mask       <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    sq_sel     <= '0;
                    move_count <= '0;
                end
                S_LATCH: begin
                    word <= fifo_word;
                    mask <= pending_mask(fifo_word);
                end
                S_EMIT: if (xfer) begin
                    mask <= mask_left;
                    if (move_count != '1) move_count <= move_count + 1'b1;
                end
                S_NEXT: if (sq_sel != SQ_W'(NUM_SQ - 1)) sq_sel <= sq_sel + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_collector.sv
module tb_move_collector;
    import move_collector_pkg::*;

    localparam int DEPTH = 48;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    move_collector_if bus();

    move_collector dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    // Behavioural square FIFOs (normal mode: data one cycle after rden)
    logic [FIFO_W-1:0] mem [NUM_SQ][DEPTH];
    int wr_ptr [NUM_SQ];
    int rd_ptr [NUM_SQ];

    int      n_checks = 0;
    int      n_fail   = 0;
    longint  cyc      = 0;
    move_t   exp_q [$];
    longint  xfer_cyc [$];
    int      rden_cnt = 0;
    int      rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    assign bus.fifo_empty = (rd_ptr[bus.sq_sel] == wr_ptr[bus.sq_sel]);

    initial bus.fifo_q = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rden && !bus.fifo_empty) begin
            bus.fifo_q <= mem[bus.sq_sel][rd_ptr[bus.sq_sel] % DEPTH];
            rd_ptr[bus.sq_sel] <= rd_ptr[bus.sq_sel] + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.mv_ready = 1'b1;
            1:       bus.mv_ready = 1'($urandom_range(0, 1));
            default: bus.mv_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    logic  stalled = 1'b0;
    move_t held;
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (bus.rden) begin
                rden_cnt++;
                check("rden_while_empty", 32'(bus.fifo_empty), 32'd0);
            end
            if (stalled) begin
                check("stall_valid", 32'(bus.mv_valid), 32'd1);
                check("stall_data", 32'(bus.mv_data), 32'(held));
            end
            if (bus.mv_valid && bus.mv_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_move", 32'(bus.mv_data), 32'h7ffff);
                else check("move_data", 32'(bus.mv_data), 32'(exp_q.pop_front()));
            end
            stalled = bus.mv_valid && !bus.mv_ready;
            held    = bus.mv_data;
        end
    end

    function automatic move_t rand_move(input bit valid);
        move_t m = move_t'($urandom);
        m[FLG_INVALID] = ~valid;
        return m;
    endfunction

    function automatic logic [FIFO_W-1:0] mk_word(input logic [NUM_SLOTS-1:0] vmask);
        logic [FIFO_W-1:0] w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NUM_SLOTS; i++) w[i*SLOT_W +: SLOT_W] = rand_move(vmask[i]);
        return w;
    endfunction

    task automatic load(input int sq, input logic [FIFO_W-1:0] w);
        mem[sq][wr_ptr[sq] % DEPTH] = w;
        wr_ptr[sq]++;
    endtask

    task automatic clear_fifos();
        for (int s = 0; s < NUM_SQ; s++) wr_ptr[s] = rd_ptr[s];
    endtask

    // Reference: walk squares in order, words in FIFO order, slots 7..0.
    task automatic run_pass(input string name, input int wait_cyc, input bit mid_start);
        int total = 0, words = 0, k = 0;
        logic [FIFO_W-1:0] w;
        for (int s = 0; s < NUM_SQ; s++)
            for (int p = rd_ptr[s]; p < wr_ptr[s]; p++) begin
                w = mem[s][p % DEPTH];
                words++;
                for (int i = NUM_SLOTS - 1; i >= 0; i--)
                    if (!w[i*SLOT_W + FLG_INVALID]) begin
                        exp_q.push_back(w[i*SLOT_W +: SLOT_W]);
                        total++;
                    end
            end
        rden_cnt = 0;
        xfer_cyc.delete();
        @(posedge clk); #1 bus.start = 1'b1; bus.all_done = 1'b0;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (wait_cyc) @(posedge clk);
        #1 bus.all_done = 1'b1;
        if (mid_start) begin
            repeat (20) @(posedge clk);
            #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
        end
        while (!bus.pass_done && k < 20000) begin @(negedge clk); k++; end
        check({name, "_pass_done"}, 32'(bus.pass_done), 32'd1);
        check({name, "_move_count"}, 32'(bus.move_count), (total > 255) ? 32'd255 : 32'(total));
        check({name, "_moves_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_xfers"}, 32'(xfer_cyc.size()), 32'(total));
        check({name, "_rden_pulses"}, 32'(rden_cnt), 32'(words));
        @(negedge clk);
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
        check({name, "_count_hold"}, 32'(bus.move_count), (total > 255) ? 32'd255 : 32'(total));
        bus.all_done = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_sq_sel"}, 32'(bus.sq_sel), 32'd0);
        check({name, "_rden"}, 32'(bus.rden), 32'd0);
        check({name, "_mv_data"}, 32'(bus.mv_data), 32'd0);
        check({name, "_mv_valid"}, 32'(bus.mv_valid), 32'd0);
        check({name, "_move_count"}, 32'(bus.move_count), 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_pass_done"}, 32'(bus.pass_done), 32'd0);
    endtask

    initial begin
        logic [FIFO_W-1:0] w;
        int k;
        bus.start = 1'b0;
        bus.all_done = 1'b0;
        bus.mv_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // All FIFOs empty, all_done already high
        run_pass("empty", 0, 1'b0);

        // Square 12: slots 7 and 2 valid
        w = mk_word(8'h00);
        w[7*SLOT_W +: SLOT_W] = 19'h00C1C;
        w[2*SLOT_W +: SLOT_W] = 19'h04C1C;
        load(12, w);
        run_pass("sq12", 3, 1'b0);
        check("sq12_first_cycle", 32'(xfer_cyc.size() == 2 ? xfer_cyc[1] - xfer_cyc[0] : 0), 32'd1);

        // Same word, downstream stalls 5 cycles
        load(12, w);
        rdy_mode = 2;
        fork
            run_pass("stall", 2, 1'b0);
            begin
                k = 0;
                while (!bus.mv_valid && k < 2000) begin @(negedge clk); k++; end
                check("stall_seen_valid", 32'(bus.mv_valid), 32'd1);
                check("stall_first_move", 32'(bus.mv_data), 32'h00C1C);
                repeat (5) @(negedge clk);
                rdy_mode = 0;
            end
        join

        // Square 0: two full words; square 63: one all-invalid word
        load(0, mk_word(8'hFF));
        load(0, mk_word(8'hFF));
        load(63, mk_word(8'h00));
        run_pass("full16", 1, 1'b0);

        // 40 full words: count saturates, all moves still delivered
        for (int i = 0; i < 20; i++) load(5, mk_word(8'hFF));
        for (int i = 0; i < 20; i++) load(40, mk_word(8'hFF));
        rdy_mode = 1;
        run_pass("sat", 4, 1'b1);

        // Random contents, random backpressure, start pulse while busy
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) load($urandom_range(0, 63), mk_word(8'($urandom)));
            run_pass("rand", $urandom_range(0, 10), 1'b1);
        end
        rdy_mode = 0;

        // Reset in the middle of EMIT on square 30
        load(30, mk_word(8'hFF));
        load(50, mk_word(8'hFF));
        rdy_mode = 2;
        @(posedge clk); #1 bus.start = 1'b1; bus.all_done = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        k = 0;
        while (!(bus.mv_valid && bus.sq_sel == 6'd30) && k < 2000) begin @(negedge clk); k++; end
        check("mid_emit_sq30", 32'(bus.sq_sel), 32'd30);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        clear_fifos();
        bus.all_done = 1'b0;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("no_resume");
        load(0, mk_word(8'hA5));
        load(63, mk_word(8'h81));
        run_pass("after_reset", 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
